// File: rtl/bpu_upd_if.sv
// ---------------------------------------------------------------------------
// bpu_upd_if
// Groups the EX branch-resolution handshake and the pattern table update
// port of the gshare predictor.
//
// EX resolution : ex_valid, ex_ready, ex_pc, ex_hist, ex_taken, ex_mispred
// Table update  : pht_rst_n, pht_we, pht_ex_pc, pht_wbhr, pht_branched
//
// Modports:
//   master - the EX stage / table side (drives ex_*, observes ex_ready, pht_*)
//   slave  - the update controller (accepts ex_*, drives ex_ready, pht_*)
// ---------------------------------------------------------------------------
interface bpu_upd_if #(
    parameter int BHR_WIDTH = 4
);
    logic                 ex_valid;
    logic                 ex_ready;
    logic [31:0]          ex_pc;
    logic [BHR_WIDTH-1:0] ex_hist;
    logic                 ex_taken;
    logic                 ex_mispred;

    logic                 pht_rst_n;
    logic                 pht_we;
    logic [31:0]          pht_ex_pc;
    logic [BHR_WIDTH-1:0] pht_wbhr;
    logic                 pht_branched;

    modport master (
        output ex_valid, ex_pc, ex_hist, ex_taken, ex_mispred,
        input  ex_ready, pht_rst_n, pht_we, pht_ex_pc, pht_wbhr, pht_branched
    );

    modport slave (
        input  ex_valid, ex_pc, ex_hist, ex_taken, ex_mispred,
        output ex_ready, pht_rst_n, pht_we, pht_ex_pc, pht_wbhr, pht_branched
    );
endinterface

// File: rtl/bpu_upd_ctrl.sv
// ---------------------------------------------------------------------------
// bpu_upd_ctrl
// Sequencer and write-port scheduler for the IF1 gshare predictor.
//  - Holds the speculative global history (fbhr) and repairs it on EX
//    mispredicts.
//  - Buffers EX resolutions in a QDEPTH-entry FIFO and drains one per cycle
//    onto the pattern table's single update port.
//  - Holds the table in synchronous reset for INIT_CYCLES cycles after
//    reset or a predictor flush.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   flush_req       - re-initialise tables and history
//   if1_valid, if1_is_br, pred_taken - IF1 slot and its prediction
//   fbhr            - speculative history to the table read index
//   bpu_ready       - predictor in RUN
//   q_count         - update queue occupancy
//   bus (slave)     - EX resolution handshake and table update port
//
// Optional feature: define BPU_UPD_BYPASS_EN to let a resolution arriving
// at an empty queue write the table in the same cycle.
// ---------------------------------------------------------------------------
module bpu_upd_ctrl #(
    parameter int BHR_WIDTH   = 4,
    parameter int QDEPTH      = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_req,
    input  logic                   if1_valid,
    input  logic                   if1_is_br,
    input  logic                   pred_taken,
    output logic [BHR_WIDTH-1:0]   fbhr,
    output logic                   bpu_ready,
    output logic [$clog2(QDEPTH):0] q_count,
    bpu_upd_if.slave               bus
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [BHR_WIDTH-1:0] hist;
        logic                 taken;
    } upd_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    upd_t          mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic run, ex_hs, push, pop, bypass;
    upd_t ex_entry;

    assign ex_entry = '{pc: bus.ex_pc, hist: bus.ex_hist, taken: bus.ex_taken};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= CW'(INIT_CYCLES - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt        = state;
        cnt_nxt          = cnt;
        run              = (state == ST_RUN);
        bus.ex_ready     = run ? (q_count < (PW+1)'(QDEPTH)) : 1'b1;
        ex_hs            = bus.ex_valid && bus.ex_ready;
        pop              = run && (q_count != '0);
`ifdef BPU_UPD_BYPASS_EN
        bypass           = run && (q_count == '0) && ex_hs && !flush_req;
`else
        bypass           = 1'b0;
`endif
        // Resolutions accepted in INIT or alongside a flush are dropped.
        push             = ex_hs && run && !flush_req && !bypass;
        bus.pht_rst_n    = run;
        bus.pht_we       = pop || bypass;
        bus.pht_ex_pc    = bypass ? ex_entry.pc    : mem[rd_ptr].pc;
        bus.pht_wbhr     = bypass ? ex_entry.hist  : mem[rd_ptr].hist;
        bus.pht_branched = bypass ? ex_entry.taken : mem[rd_ptr].taken;

        if (flush_req) begin
            state_nxt = ST_INIT;
            cnt_nxt   = CW'(INIT_CYCLES - 1);
        end else if (state == ST_INIT) begin
            if (cnt == '0) state_nxt = ST_RUN;
            else           cnt_nxt   = cnt - 1'b1;
        end
    end

    assign bpu_ready = run;

    // ---------------- Speculative history ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fbhr <= '0;
        end else if (flush_req) begin
            fbhr <= '0;
        end else if (ex_hs && bus.ex_mispred) begin
            // Repair from the snapshot the branch carried, then append its
            // real outcome; this beats any same-cycle IF1 shift.
            fbhr <= {bus.ex_hist[BHR_WIDTH-2:0], bus.ex_taken};
        end else if (if1_valid && if1_is_br && run) begin
            fbhr <= {fbhr[BHR_WIDTH-2:0], pred_taken};
        end
    end

    // ---------------- Update queue control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (flush_req) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      q_count <= q_count + 1'b1;
            else if (pop && !push) q_count <= q_count - 1'b1;
        end
    end

    // NOTE: queue storage has no reset; q_count guards every read, so stale
    // contents are never observed and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ex_entry;
    end

endmodule

// File: tb/tb_bpu_upd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpu_upd_ctrl
// Self-checking bench for bpu_upd_ctrl. A behavioural model (mode flag,
// init countdown, occupancy, history as integers) advances on each rising
// edge; accepted resolutions are pushed into a scoreboard queue when issued
// and a separate monitor pops and compares on every table write.
// ---------------------------------------------------------------------------
module tb_bpu_upd_ctrl;

    localparam int BW   = 4;
    localparam int QD   = 4;
    localparam int INIT = 2;
`ifdef BPU_UPD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_req, if1_valid, if1_is_br, pred_taken;
    logic [BW-1:0] fbhr;
    logic          bpu_ready;
    logic [2:0]    q_count;

    bpu_upd_if #(.BHR_WIDTH(BW)) bus ();

    bpu_upd_ctrl #(.BHR_WIDTH(BW), .QDEPTH(QD), .INIT_CYCLES(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_req (flush_req),
        .if1_valid (if1_valid),
        .if1_is_br (if1_is_br),
        .pred_taken(pred_taken),
        .fbhr      (fbhr),
        .bpu_ready (bpu_ready),
        .q_count   (q_count),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [BW-1:0] hist;
        logic          taken;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    bit m_run;
    int m_left;
    int m_cnt;
    int m_fbhr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances with the inputs present just before each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_left = INIT; m_cnt = 0; m_fbhr = 0;
            exp_q.delete();
        end else begin
            bit acc, byp, push, pop;
            acc  = bus.ex_valid && (m_run ? (m_cnt < QD) : 1'b1);
            byp  = BYP && m_run && (m_cnt == 0) && acc && !flush_req;
            push = acc && m_run && !flush_req && !byp;
            pop  = m_run && (m_cnt != 0);
            if (flush_req)                       m_fbhr = 0;
            else if (acc && bus.ex_mispred)      m_fbhr = ((int'(bus.ex_hist) << 1) | int'(bus.ex_taken)) % (1 << BW);
            else if (if1_valid && if1_is_br && m_run) m_fbhr = ((m_fbhr << 1) | int'(pred_taken)) % (1 << BW);
            if (flush_req) m_cnt = 0;
            else           m_cnt = m_cnt + int'(push) - int'(pop);
            if (flush_req) begin
                m_run = 0; m_left = INIT;
                exp_q.delete();
            end else if (!m_run) begin
                m_left--;
                if (m_left == 0) m_run = 1;
            end
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on writes.
    always @(negedge clk) begin
        if (!rst) begin
            bit exp_rdy, byp, exp_we;
            ent_t e;
            exp_rdy = m_run ? (m_cnt < QD) : 1'b1;
            byp     = BYP && m_run && (m_cnt == 0) && bus.ex_valid && exp_rdy && !flush_req;
            exp_we  = m_run && ((m_cnt != 0) || byp);
            check("ex_ready",  64'(bus.ex_ready),  64'(exp_rdy));
            check("bpu_ready", 64'(bpu_ready),     64'(m_run));
            check("pht_rst_n", 64'(bus.pht_rst_n), 64'(m_run));
            check("q_count",   64'(q_count),       64'(m_cnt));
            check("fbhr",      64'(fbhr),          64'(m_fbhr));
            check("pht_we",    64'(bus.pht_we),    64'(exp_we));
            if (bus.pht_we && exp_we) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pht_ex_pc",    64'(bus.pht_ex_pc),    64'(e.pc));
                    check("pht_wbhr",     64'(bus.pht_wbhr),     64'(e.hist));
                    check("pht_branched", 64'(bus.pht_branched), 64'(e.taken));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs; record the expected write if it is accepted.
    task automatic drive(input bit fl, input bit iv, input bit ib, input bit pt,
                         input bit ev, input logic [31:0] pc, input logic [BW-1:0] h,
                         input bit tk, input bit mp);
        flush_req      = fl;
        if1_valid      = iv;
        if1_is_br      = ib;
        pred_taken     = pt;
        bus.ex_valid   = ev;
        bus.ex_pc      = pc;
        bus.ex_hist    = h;
        bus.ex_taken   = tk;
        bus.ex_mispred = mp;
        if (ev && m_run && (m_cnt < QD) && !fl)
            exp_q.push_back(ent_t'{pc: pc, hist: h, taken: tk});
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 32'h0, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) cyc();
        rst = 1'b0;
        // Init window: table reset low for two edges, then RUN.
        check("init_rst_n_0", 64'(bus.pht_rst_n), 64'd0);
        check("init_ready_0", 64'(bpu_ready),     64'd0);
        cyc();
        check("init_rst_n_1", 64'(bus.pht_rst_n), 64'd0);
        cyc();
        check("run_rst_n",    64'(bus.pht_rst_n), 64'd1);
        check("run_ready",    64'(bpu_ready),     64'd1);
        check("run_fbhr",     64'(fbhr),          64'd0);

        // Predictions taken, taken, not-taken.
        drive(0, 1, 1, 1, 0, 32'h0, '0, 0, 0); cyc();
        check("fbhr_t",   64'(fbhr), 64'h1);
        drive(0, 1, 1, 1, 0, 32'h0, '0, 0, 0); cyc();
        check("fbhr_tt",  64'(fbhr), 64'h3);
        drive(0, 1, 1, 0, 0, 32'h0, '0, 0, 0); cyc();
        check("fbhr_ttn", 64'(fbhr), 64'h6);

        // Repair beats a same-cycle IF1 shift.
        drive(0, 1, 1, 1, 1, 32'h100, 4'h5, 1, 1); cyc();
        check("fbhr_repair", 64'(fbhr), 64'hB);
        idle();
        repeat (3) cyc();

        // Five back-to-back resolutions.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 32'h200 + 32'(i * 4), 4'(i), 1'(i), 0);
            cyc();
        end
        idle();
        repeat (3) cyc();

        // Flush together with a handshake while an entry is queued.
        drive(0, 0, 0, 0, 1, 32'h300, 4'h3, 1, 0); cyc();
        check("pre_flush_q", 64'(q_count), BYP ? 64'd0 : 64'd1);
        drive(1, 0, 0, 0, 1, 32'h304, 4'h7, 1, 1); cyc();
        idle();
        check("flush_q",     64'(q_count),   64'd0);
        check("flush_fbhr",  64'(fbhr),      64'd0);
        check("flush_rdy_0", 64'(bpu_ready), 64'd0);
        cyc();
        check("flush_rdy_1", 64'(bpu_ready), 64'd0);
        cyc();
        check("flush_rdy_2", 64'(bpu_ready), 64'd1);

        // Resolution at an empty queue.
        drive(0, 0, 0, 0, 1, 32'h1C0, 4'h2, 1, 0);
        #1;
        check("byp_we",   64'(bus.pht_we), 64'(BYP));
        check("byp_q_0",  64'(q_count),    64'd0);
        cyc();
        idle();
        check("byp_q_1",  64'(q_count),    BYP ? 64'd0 : 64'd1);
        repeat (2) cyc();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) < 2), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 60), $urandom, 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 30));
            cyc();
        end
        idle();
        repeat (8) cyc();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
